// File: rtl/mod_arbiter_if.sv
// Bus bundle between the round-robin arbiter and its environment: the
// requester-side handshake (req/operands in, ack/response out) and the
// shared modulo unit side (start/operands out, done/result in).
interface mod_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 32
);
  // requester side
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       ack;
  logic [WIDTH-1:0]       rsp_result;
  logic                   rsp_err;
  // shared modulo unit side
  logic                   mod_start;
  logic [WIDTH-1:0]       mod_a;
  logic [WIDTH-1:0]       mod_b;
  logic                   mod_reset;
  logic [WIDTH-1:0]       mod_result;
  logic                   mod_done;

  // arbiter view
  modport master (
    input  req, req_a, req_b, mod_result, mod_done,
    output ack, rsp_result, rsp_err, mod_start, mod_a, mod_b, mod_reset
  );

  // environment view (clients plus the modulo unit)
  modport slave (
    output req, req_a, req_b, mod_result, mod_done,
    input  ack, rsp_result, rsp_err, mod_start, mod_a, mod_b, mod_reset
  );
endinterface

// File: rtl/mod_arbiter.sv
// Round-robin arbiter that shares one sequential modulo unit among N_REQ
// clients. The winner's operands are latched, the unit is started, and its
// result is returned with a one-cycle one-hot ack. A zero divisor is answered
// immediately with an error; a unit that never finishes is reset and the
// client gets an error response.
module mod_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  output logic         busy,
  mod_arbiter_if.master bus
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_ABORT,
    S_RESP
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q, last_d;
  logic [IW-1:0]    grant_q, grant_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    cnt_inc;

  logic             pick_vld;
  logic [IW-1:0]    pick_idx;
  logic [WIDTH-1:0] pick_a;
  logic [WIDTH-1:0] pick_b;

  // Returns {found, index} of the first set request after 'last', wrapping.
  // Scanning from the farthest offset down lets the nearest one win, and the
  // previous winner itself (offset N_REQ) ends up with the lowest priority.
  function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] req,
                                          input logic [IW-1:0]    last);
    logic [IW:0]   r;
    logic [IW-1:0] sel;
    int            idx;
    r = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      idx = int'(last) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      sel = IW'(idx);
      if (req[sel]) r = {1'b1, sel};
    end
    return r;
  endfunction

  // Arbitration and operand mux for the current winner candidate.
  always_comb begin
    int base;
    {pick_vld, pick_idx} = rr_pick(bus.req, last_q);
    base    = int'(pick_idx) * WIDTH;
    pick_a  = bus.req_a[base +: WIDTH];
    pick_b  = bus.req_b[base +: WIDTH];
    cnt_inc = cnt_q + CW'(1);
  end

  // Next-state logic and output decode of the sequencing FSM.
  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    grant_d        = grant_q;
    a_d            = a_q;
    b_d            = b_q;
    res_d          = res_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    busy           = (state_q != S_IDLE);
    bus.mod_start  = 1'b0;
    bus.mod_reset  = reset;
    bus.mod_a      = a_q;
    bus.mod_b      = b_q;
    bus.ack        = '0;
    bus.rsp_result = '0;
    bus.rsp_err    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          a_d     = pick_a;
          b_d     = pick_b;
          cnt_d   = '0;
          if (pick_b == '0) begin
            // zero divisor: answer at once, the unit is never started
            res_d   = '0;
            err_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            err_d   = 1'b0;
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        bus.mod_start = 1'b1;
        cnt_d         = '0;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        if (bus.mod_done) begin
          res_d   = bus.mod_result;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) state_d = S_ABORT;
        end
      end
      S_ABORT: begin
        bus.mod_reset = 1'b1;
        res_d         = '0;
        err_d         = 1'b1;
        state_d       = S_RESP;
      end
      S_RESP: begin
        bus.ack        = N_REQ'(1) << grant_q;
        bus.rsp_result = res_q;
        bus.rsp_err    = err_q;
        last_d         = grant_q;
        state_d        = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= IW'(N_REQ - 1);
      grant_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mod_arbiter.sv
// Directed bench for mod_arbiter with a behavioural modulo unit and a
// scoreboard of expected responses checked whenever an ack appears.
module tb_mod_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  logic busy;
  int   cyc = 0;
  int   n_check = 0;
  int   n_pass = 0;
  int   n_start = 0;
  int   n_abort = 0;

  typedef struct {
    logic [N-1:0] ack;
    logic [W-1:0] res;
    logic         err;
  } exp_t;
  exp_t sb[$];

  mod_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus();

  mod_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .reset (reset),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // behavioural modulo unit: done in the model_d-th WAIT cycle unless hung
  int           model_d = 4;
  logic         model_hang = 1'b0;
  logic         m_active = 1'b0;
  logic         m_done = 1'b0;
  int           m_cnt = 0;
  logic [W-1:0] m_res = '0;
  assign bus.mod_done   = m_done;
  assign bus.mod_result = m_res;

  always @(posedge clk) begin
    if (bus.mod_reset) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
    end else if (bus.mod_start) begin
      m_active <= 1'b1;
      m_cnt    <= 1;
      m_res    <= bus.mod_a % bus.mod_b;
      m_done   <= !model_hang && (model_d == 1);
    end else if (m_active) begin
      if (m_done) begin
        m_active <= 1'b0;
        m_done   <= 1'b0;
      end else begin
        m_cnt  <= m_cnt + 1;
        m_done <= !model_hang && (m_cnt + 1 == model_d);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_check++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
  endtask

  // scoreboard monitor and event counters
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.mod_start) n_start++;
      if (bus.mod_reset) n_abort++;
      if (bus.ack != '0) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_ack", 64'(bus.ack), 64'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_ack", 64'(bus.ack), 64'(e.ack));
          chk("sb_result", 64'(bus.rsp_result), 64'(e.res));
          chk("sb_err", 64'(bus.rsp_err), 64'(e.err));
        end
      end
    end
  end

  task automatic push(input logic [N-1:0] a, input logic [W-1:0] r, input logic e);
    exp_t x;
    x.ack = a; x.res = r; x.err = e;
    sb.push_back(x);
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  task automatic wait_ack(output int c);
    c = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.ack != '0) begin
        c = cyc;
        return;
      end
    end
    chk("ack_wait_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired n_pass=%0d n_check=%0d", n_pass, n_check);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, c, prev, s0, r0;
    reset     = 1'b1;
    bus.req   = '0;
    bus.req_a = '0;
    bus.req_b = '0;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(bus.ack), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_start", 64'(bus.mod_start), 64'd0);
    chk("rst_mod_a", 64'(bus.mod_a), 64'd0);
    chk("rst_mod_b", 64'(bus.mod_b), 64'd0);
    chk("rst_result", 64'(bus.rsp_result), 64'd0);
    chk("rst_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_mod_reset", 64'(bus.mod_reset), 64'd1);
    reset = 1'b0;

    // all four held: grants 0,1,2,3,0,1 each with its own a mod b
    @(posedge clk); #1;
    model_d = 2;
    set_op(0, 50, 7); set_op(1, 61, 8); set_op(2, 77, 9); set_op(3, 95, 10);
    push(4'b0001, 1, 0); push(4'b0010, 5, 0); push(4'b0100, 5, 0);
    push(4'b1000, 5, 0); push(4'b0001, 1, 0); push(4'b0010, 5, 0);
    s0 = n_start;
    bus.req = 4'b1111;
    prev = -1;
    for (int k = 0; k < 6; k++) begin
      wait_ack(c);
      if (prev >= 0) chk("rr_spacing", 64'(c - prev), 64'd5);
      prev = c;
    end
    bus.req = '0;
    chk("rr_starts", 64'(n_start - s0), 64'd6);

    // single request, done after 4 WAIT cycles
    @(posedge clk); #1;
    model_d = 4;
    set_op(0, 17, 5);
    push(4'b0001, 2, 0);
    s0 = n_start;
    t = cyc;
    bus.req = 4'b0001;
    wait_ack(c);
    bus.req = '0;
    chk("t1_latency", 64'(c), 64'(t + 6));
    chk("t1_starts", 64'(n_start - s0), 64'd1);

    // zero divisor: immediate error, unit untouched
    @(posedge clk); #1;
    set_op(2, 99, 0);
    push(4'b0100, 0, 1);
    s0 = n_start;
    t = cyc;
    bus.req = 4'b0100;
    wait_ack(c);
    bus.req = '0;
    chk("t3_latency", 64'(c), 64'(t + 1));
    chk("t3_starts", 64'(n_start - s0), 64'd0);

    // hung unit: abort with error, then a normal op
    @(posedge clk); #1;
    model_hang = 1'b1;
    set_op(1, 40, 6);
    push(4'b0010, 0, 1);
    s0 = n_start;
    r0 = n_abort;
    t = cyc;
    bus.req = 4'b0010;
    wait_ack(c);
    bus.req = '0;
    model_hang = 1'b0;
    chk("t4_latency", 64'(c), 64'(t + TO + 3));
    chk("t4_aborts", 64'(n_abort - r0), 64'd1);
    chk("t4_starts", 64'(n_start - s0), 64'd1);
    @(posedge clk); #1;
    model_d = 3;
    set_op(0, 10, 3);
    push(4'b0001, 1, 0);
    t = cyc;
    bus.req = 4'b0001;
    wait_ack(c);
    bus.req = '0;
    chk("t4_after_latency", 64'(c), 64'(t + 5));

    // reset during WAIT: no ack, then requester 0 wins first
    @(posedge clk); #1;
    model_d = 20;
    set_op(0, 1000, 7);
    bus.req = 4'b0001;
    repeat (4) @(posedge clk); #1;
    chk("t5_busy_in_wait", 64'(busy), 64'd1);
    reset = 1'b1;
    set_op(1, 61, 8); set_op(2, 77, 9); set_op(3, 95, 10);
    bus.req = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_ack", 64'(bus.ack), 64'd0);
    chk("t5_start", 64'(bus.mod_start), 64'd0);
    chk("t5_mod_a", 64'(bus.mod_a), 64'd0);
    chk("t5_err", 64'(bus.rsp_err), 64'd0);
    reset = 1'b0;
    model_d = 2;
    push(4'b0001, 6, 0); push(4'b0010, 5, 0);
    push(4'b0100, 5, 0); push(4'b1000, 5, 0);
    for (int k = 0; k < 4; k++) begin
      wait_ack(c);
      bus.req = bus.req & ~bus.ack;
    end

    // request dropped and operand changed after grant
    @(posedge clk); #1;
    model_d = 3;
    set_op(1, 55, 6);
    push(4'b0010, 1, 0);
    t = cyc;
    bus.req = 4'b0010;
    @(posedge clk); #1;
    bus.req = '0;
    set_op(1, 20, 6);
    @(posedge clk); #1;
    chk("t6_mod_a_latched", 64'(bus.mod_a), 64'd55);
    wait_ack(c);
    chk("t6_latency", 64'(c), 64'(t + 5));
    repeat (3) @(negedge clk);
    chk("t6_idle_after", 64'(busy), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
